z16_mc_core: RTL and testbench

Parametrised multi-cycle Z16 processor core. Replaces the single-cycle datapath with a fetch/decode/execute/memory/writeback state machine. Instructions and data share one memory port that uses a request/acknowledge handshake, so wait-state memories and a shared bus can sit behind it. Data width and address width are parameters. The core adds a conditional branch, halt, an illegal-opcode flag and a retire strobe for trace and verification.

---
 rtl/z16_pkg.sv | 50 +++++
 rtl/z16_alu_p.sv | 25 ++
 rtl/z16_mc_core.sv | 206 ++++++++++++++++++++
 tb/tb_z16_mc_core.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/z16_pkg.sv
// Shared definitions for the Z16 multi-cycle core: opcodes, FSM states, field positions.
package z16_pkg;

  localparam int unsigned INSTR_W  = 16;
  localparam int unsigned NUM_REGS = 16;
  localparam int unsigned REG_AW   = 4;

  // Instruction field bit positions
  localparam int unsigned OP_HI  = 15;
  localparam int unsigned OP_LO  = 12;
  localparam int unsigned RD_HI  = 11;
  localparam int unsigned RD_LO  = 8;
  localparam int unsigned RS1_HI = 7;
  localparam int unsigned RS1_LO = 4;
  localparam int unsigned RS2_HI = 3;
  localparam int unsigned RS2_LO = 0;

  // Opcodes
  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_ADDI = 4'h4;
  localparam logic [3:0] OP_LD   = 4'h5;
  localparam logic [3:0] OP_ST   = 4'h6;
  localparam logic [3:0] OP_BNZ  = 4'h7;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_e;

  // ALU encodings line up with opcodes 0..3 so the low opcode bits select directly
  typedef enum logic [1:0] {
    ALU_ADD = 2'd0,
    ALU_SUB = 2'd1,
    ALU_AND = 2'd2,
    ALU_OR  = 2'd3
  } alu_op_e;

  function automatic logic op_legal(input logic [3:0] op);
    return (op <= OP_BNZ) || (op == OP_HALT);
  endfunction

endpackage

// File: rtl/z16_alu_p.sv
// Combinational Z16 ALU: add / subtract / and / or, wrapping at DATA_W bits.
module z16_alu_p
  import z16_pkg::*;
#(
  parameter int unsigned DATA_W = 16
) (
  input  logic [1:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] y
);

  // Operation select
  always_comb begin
    y = '0;
    unique case (op)
      ALU_ADD: y = a + b;
      ALU_SUB: y = a - b;
      ALU_AND: y = a & b;
      ALU_OR:  y = a | b;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/z16_mc_core.sv
// Multi-cycle Z16 core: fetch/decode/exec/mem/writeback over one req/ack memory port.
module z16_mc_core
  import z16_pkg::*;
#(
  parameter int unsigned      DATA_W   = 16,
  parameter int unsigned      ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              i_clk,
  input  logic              i_rst,
  output logic              o_mem_req,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic              i_mem_ack,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic [ADDR_W-1:0] o_pc,
  output logic              o_retire,
  output logic              o_illegal,
  output logic              o_halted
);

  state_e              state, state_n;
  logic [ADDR_W-1:0]   pc_n;
  logic [INSTR_W-1:0]  ir, ir_n;
  logic [DATA_W-1:0]   op_a, op_a_n, op_b, op_b_n, res, res_n;
  logic                req_n, we_n, retire_n, illegal_n, halted_n, rf_we;
  logic [ADDR_W-1:0]   addr_n;
  logic [DATA_W-1:0]   wdata_n;

  logic [DATA_W-1:0]   rf [NUM_REGS];

  logic [3:0]          op;
  logic [REG_AW-1:0]   rd, rs1, rs2;
  logic [DATA_W-1:0]   imm, rs1_val, rs2_val, rd_val, alu_b, alu_y;
  logic [ADDR_W-1:0]   pc_inc, br_off;
  logic [1:0]          alu_op;
  logic                use_imm;

  assign op  = ir[OP_HI:OP_LO];
  assign rd  = ir[RD_HI:RD_LO];
  assign rs1 = ir[RS1_HI:RS1_LO];
  assign rs2 = ir[RS2_HI:RS2_LO];

  assign imm    = DATA_W'($signed(ir[RS2_HI:RS2_LO]));
  assign br_off = ADDR_W'($signed({ir[RD_HI:RD_LO], ir[RS2_HI:RS2_LO]})) << 1;
  assign pc_inc = o_pc + ADDR_W'(2);

  // r0 is hard-wired to zero on read
  assign rs1_val = (rs1 == '0) ? '0 : rf[rs1];
  assign rs2_val = (rs2 == '0) ? '0 : rf[rs2];
  assign rd_val  = (rd  == '0) ? '0 : rf[rd];

  assign use_imm = (op == OP_ADDI) || (op == OP_LD) || (op == OP_ST);
  assign alu_b   = use_imm ? imm : op_b;
  assign alu_op  = (op <= OP_OR) ? op[1:0] : ALU_ADD;

  z16_alu_p #(.DATA_W(DATA_W)) u_alu (
    .op (alu_op),
    .a  (op_a),
    .b  (alu_b),
    .y  (alu_y)
  );

  // Next-state and next-output logic
  always_comb begin
    state_n   = state;
    pc_n      = o_pc;
    ir_n      = ir;
    op_a_n    = op_a;
    op_b_n    = op_b;
    res_n     = res;
    req_n     = o_mem_req;
    we_n      = o_mem_we;
    addr_n    = o_mem_addr;
    wdata_n   = o_mem_wdata;
    retire_n  = 1'b0;
    illegal_n = 1'b0;
    halted_n  = 1'b0;
    rf_we     = 1'b0;

    unique case (state)
      S_FETCH: begin
        // Only reached with req low straight out of reset
        if (!o_mem_req) begin
          req_n  = 1'b1;
          we_n   = 1'b0;
          addr_n = o_pc;
        end else if (i_mem_ack) begin
          ir_n    = i_mem_rdata[INSTR_W-1:0];
          req_n   = 1'b0;
          state_n = S_DECODE;
        end
      end
      S_DECODE: begin
        op_a_n    = rs1_val;
        op_b_n    = (op == OP_ST) ? rd_val : rs2_val;
        illegal_n = !op_legal(op);
        state_n   = S_EXEC;
      end
      S_EXEC: begin
        res_n = alu_y;
        case (op)
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI: state_n = S_WB;
          OP_LD, OP_ST: begin
            state_n = S_MEM;
            req_n   = 1'b1;
            we_n    = (op == OP_ST);
            addr_n  = ADDR_W'(alu_y);
            wdata_n = op_b;
          end
          OP_BNZ: begin
            pc_n     = (op_a != '0) ? (pc_inc + br_off) : pc_inc;
            retire_n = 1'b1;
            state_n  = S_FETCH;
          end
          OP_HALT: begin
            retire_n = 1'b1;
            state_n  = S_HALT;
          end
          default: begin
            pc_n     = pc_inc;
            retire_n = 1'b1;
            state_n  = S_FETCH;
          end
        endcase
      end
      S_MEM: begin
        if (o_mem_req && i_mem_ack) begin
          req_n = 1'b0;
          we_n  = 1'b0;
          if (op == OP_ST) begin
            pc_n     = pc_inc;
            retire_n = 1'b1;
            state_n  = S_FETCH;
          end else begin
            res_n   = i_mem_rdata;
            state_n = S_WB;
          end
        end
      end
      S_WB: begin
        rf_we    = 1'b1;
        pc_n     = pc_inc;
        retire_n = 1'b1;
        state_n  = S_FETCH;
      end
      S_HALT: begin
        state_n = S_HALT;
      end
      default: state_n = S_FETCH;
    endcase

    // Raise the next fetch on the same edge that completes the previous instruction
    if ((state_n == S_FETCH) && (state != S_FETCH)) begin
      req_n  = 1'b1;
      we_n   = 1'b0;
      addr_n = pc_n;
    end

    halted_n = (state_n == S_HALT);
  end

  // State, datapath and output registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= S_FETCH;
      o_pc        <= RESET_PC;
      ir          <= '0;
      op_a        <= '0;
      op_b        <= '0;
      res         <= '0;
      o_mem_req   <= 1'b0;
      o_mem_we    <= 1'b0;
      o_mem_addr  <= '0;
      o_mem_wdata <= '0;
      o_retire    <= 1'b0;
      o_illegal   <= 1'b0;
      o_halted    <= 1'b0;
    end else begin
      state       <= state_n;
      o_pc        <= pc_n;
      ir          <= ir_n;
      op_a        <= op_a_n;
      op_b        <= op_b_n;
      res         <= res_n;
      o_mem_req   <= req_n;
      o_mem_we    <= we_n;
      o_mem_addr  <= addr_n;
      o_mem_wdata <= wdata_n;
      o_retire    <= retire_n;
      o_illegal   <= illegal_n;
      o_halted    <= halted_n;
    end
  end

  // Register file; writes to r0 are dropped
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < int'(NUM_REGS); i++) rf[i] <= '0;
    end else if (rf_we && (rd != '0)) begin
      rf[rd] <= res;
    end
  end

endmodule

// File: tb/tb_z16_mc_core.sv
// Directed bench for z16_mc_core: 16/16 core with wait-state memory, plus a 32/12 core.
module tb_z16_mc_core;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 16-bit data / 16-bit address instance
  logic        rst, req, we, ack, retire, illegal, halted;
  logic [15:0] addr, wdata, rdata, pc;

  // 32-bit data / 12-bit address instance
  logic        rst32, req32, we32, ack32, retire32, illegal32, halted32;
  logic [11:0] addr32, pc32;
  logic [31:0] wdata32, rdata32;

  z16_mc_core #(.DATA_W(16), .ADDR_W(16), .RESET_PC(16'h0000)) u_dut (
    .i_clk(clk), .i_rst(rst),
    .o_mem_req(req), .o_mem_we(we), .o_mem_addr(addr), .o_mem_wdata(wdata),
    .i_mem_ack(ack), .i_mem_rdata(rdata),
    .o_pc(pc), .o_retire(retire), .o_illegal(illegal), .o_halted(halted)
  );

  z16_mc_core #(.DATA_W(32), .ADDR_W(12), .RESET_PC(12'hFFC)) u_dut32 (
    .i_clk(clk), .i_rst(rst32),
    .o_mem_req(req32), .o_mem_we(we32), .o_mem_addr(addr32), .o_mem_wdata(wdata32),
    .i_mem_ack(ack32), .i_mem_rdata(rdata32),
    .o_pc(pc32), .o_retire(retire32), .o_illegal(illegal32), .o_halted(halted32)
  );

  // Memory for the 16-bit core: separate wait-state counts for fetches and data accesses
  logic [15:0] mem16 [256];
  int          fetch_ws, data_ws, wcnt, n_wr;
  logic        ack_q, ack_force;
  logic [15:0] wr_addr, wr_data;

  assign ack = ack_q | ack_force;

  always @(negedge clk) begin
    ack_q = 1'b0;
    if (req) begin
      if (wcnt >= (((addr == pc) && !we) ? fetch_ws : data_ws)) begin
        ack_q = 1'b1;
        wcnt  = 0;
        rdata = mem16[addr[8:1]];
        if (we) begin
          mem16[addr[8:1]] = wdata;
          n_wr++;
          wr_addr = addr;
          wr_data = wdata;
        end
      end else begin
        wcnt++;
      end
    end else begin
      wcnt = 0;
    end
  end

  // Zero-wait memory for the 32-bit core
  logic [31:0] mem32 [2048];
  logic        saw_fetch0;
  assign ack32   = req32;
  assign rdata32 = mem32[addr32[11:1]];

  always @(posedge clk) begin
    if (req32 && we32) mem32[addr32[11:1]] <= wdata32;
  end

  always @(negedge clk) begin
    if (!rst32 && req32 && !we32 && (addr32 == 12'h000)) saw_fetch0 = 1'b1;
  end

  // Bookkeeping
  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;
  int last  = 0;
  int n_ill = 0;

  typedef struct {
    string       name;
    logic [31:0] pc;
    int          lat;
    logic [3:0]  rd;
    logic [31:0] val;
  } vec_t;

  vec_t tv   [18];
  vec_t tv32 [4];

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Wait for the next retire pulse of the selected core; lat = cycles since previous start
  task automatic wait_ret(input bit sel, output int lat, output bit ok);
    ok  = 1'b0;
    lat = 0;
    for (int k = 0; k < 60; k++) begin
      tick();
      if (!sel && illegal) n_ill++;
      if (sel ? retire32 : retire) begin
        lat  = cyc - last;
        last = cyc;
        ok   = 1'b1;
        break;
      end
    end
    if (!ok) chk("retire_timeout", 32'(ok), 32'd1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int  lat;
    bit  ok, found;
    int  nreq;

    // Program for the 16-bit core
    tv[0]  = '{"addi_r1_5",   32'h0002, 4, 4'd1, 32'h0005};
    tv[1]  = '{"addi_r2_m3",  32'h0004, 4, 4'd2, 32'hFFFD};
    tv[2]  = '{"add_r3",      32'h0006, 4, 4'd3, 32'h0002};
    tv[3]  = '{"st_r3",       32'h0008, 6, 4'd3, 32'h0002};
    tv[4]  = '{"ld_r4",       32'h000A, 7, 4'd4, 32'h0002};
    tv[5]  = '{"sub_r5",      32'h000C, 4, 4'd5, 32'h0008};
    tv[6]  = '{"and_r6",      32'h000E, 4, 4'd6, 32'h0005};
    tv[7]  = '{"or_r7",       32'h0010, 4, 4'd7, 32'hFFFD};
    tv[8]  = '{"addi_r0",     32'h0012, 4, 4'd0, 32'h0000};
    tv[9]  = '{"addi_r1_3",   32'h0014, 4, 4'd1, 32'h0003};
    tv[10] = '{"loop_dec1",   32'h0016, 4, 4'd1, 32'h0002};
    tv[11] = '{"bnz_taken1",  32'h0014, 3, 4'd1, 32'h0002};
    tv[12] = '{"loop_dec2",   32'h0016, 4, 4'd1, 32'h0001};
    tv[13] = '{"bnz_taken2",  32'h0014, 3, 4'd1, 32'h0001};
    tv[14] = '{"loop_dec3",   32'h0016, 4, 4'd1, 32'h0000};
    tv[15] = '{"bnz_fall",    32'h0018, 3, 4'd1, 32'h0000};
    tv[16] = '{"illegal_nop", 32'h001A, 3, 4'd1, 32'h0000};
    tv[17] = '{"halt",        32'h001A, 3, 4'd7, 32'hFFFD};

    tv32[0] = '{"w_addi_r2",  32'h0FFE, 4, 4'd2, 32'h0000_0001};
    tv32[1] = '{"w_sub_wrap", 32'h0000, 4, 4'd1, 32'hFFFF_FFFF};
    tv32[2] = '{"w_addi_r3",  32'h0002, 4, 4'd3, 32'h0000_0001};
    tv32[3] = '{"w_halt",     32'h0002, 3, 4'd3, 32'h0000_0001};

    for (int i = 0; i < 256; i++)  mem16[i] = 16'h0000;
    for (int i = 0; i < 2048; i++) mem32[i] = 32'h0;
    mem16[0]  = 16'h4105;  // ADDI r1,r0,5
    mem16[1]  = 16'h420D;  // ADDI r2,r0,-3
    mem16[2]  = 16'h0312;  // ADD  r3,r1,r2
    mem16[3]  = 16'h6304;  // ST   r3,[r0+4]
    mem16[4]  = 16'h5404;  // LD   r4,[r0+4]
    mem16[5]  = 16'h1512;  // SUB  r5,r1,r2
    mem16[6]  = 16'h2612;  // AND  r6,r1,r2
    mem16[7]  = 16'h3712;  // OR   r7,r1,r2
    mem16[8]  = 16'h4011;  // ADDI r0,r1,1
    mem16[9]  = 16'h4103;  // ADDI r1,r0,3
    mem16[10] = 16'h411F;  // ADDI r1,r1,-1
    mem16[11] = 16'h7F1E;  // BNZ  r1,-2
    mem16[12] = 16'h8123;  // undefined opcode
    mem16[13] = 16'hF000;  // HALT

    mem32[11'h7FE] = 32'h0000_4201;  // ADDI r2,r0,1
    mem32[11'h7FF] = 32'h0000_1102;  // SUB  r1,r0,r2
    mem32[11'h000] = 32'h0000_4312;  // ADDI r3,r1,2
    mem32[11'h001] = 32'h0000_F000;  // HALT

    rst = 1'b1; rst32 = 1'b1;
    fetch_ws = 0; data_ws = 2; wcnt = 0; n_wr = 0;
    ack_q = 1'b0; ack_force = 1'b0; saw_fetch0 = 1'b0;
    wr_addr = 16'h0; wr_data = 16'h0; rdata = 16'h0;

    // Reset state
    repeat (3) tick();
    chk("rst_req",     32'(req),     32'd0);
    chk("rst_we",      32'(we),      32'd0);
    chk("rst_addr",    32'(addr),    32'd0);
    chk("rst_wdata",   32'(wdata),   32'd0);
    chk("rst_pc",      32'(pc),      32'd0);
    chk("rst_retire",  32'(retire),  32'd0);
    chk("rst_illegal", 32'(illegal), 32'd0);
    chk("rst_halted",  32'(halted),  32'd0);

    // First request one cycle after reset release
    rst = 1'b0;
    tick();
    chk("first_req",  32'(req),  32'd1);
    chk("first_addr", 32'(addr), 32'd0);
    last = cyc;

    // Main program, one record per retired instruction
    for (int i = 0; i < 18; i++) begin
      wait_ret(1'b0, lat, ok);
      if (ok) begin
        chk({tv[i].name, "_pc"},  32'(pc),  tv[i].pc);
        chk({tv[i].name, "_lat"}, 32'(lat), 32'(tv[i].lat));
        chk({tv[i].name, "_reg"}, 32'(u_dut.rf[tv[i].rd]), tv[i].val);
      end
    end

    chk("halted",       32'(halted), 32'd1);
    chk("illegal_once", 32'(n_ill),  32'd1);
    chk("store_count",  32'(n_wr),   32'd1);
    chk("store_addr",   32'(wr_addr), 32'h0004);
    chk("store_data",   32'(wr_data), 32'h0002);
    nreq = 0;
    repeat (20) begin
      tick();
      if (req) nreq++;
    end
    chk("halt_no_req", 32'(nreq), 32'd0);

    // Reset while a load waits in MEM, then a stray ack right after release
    rst = 1'b1;
    mem16[0] = 16'h5404;  // LD r4,[r0+4]
    data_ws = 50;
    repeat (2) tick();
    chk("rst2_halted", 32'(halted), 32'd0);
    rst = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      tick();
      if (req && !we && (addr == 16'h0004)) found = 1'b1;
    end
    chk("mem_wait_reached", 32'(found), 32'd1);
    rst = 1'b1;
    tick();
    chk("rst_drops_req", 32'(req), 32'd0);
    rst = 1'b0;
    ack_force = 1'b1;
    data_ws = 0;
    tick();
    ack_force = 1'b0;
    chk("restart_req",  32'(req),  32'd1);
    chk("restart_addr", 32'(addr), 32'd0);
    chk("restart_pc",   32'(pc),   32'd0);
    chk("regs_cleared", 32'(u_dut.rf[4]), 32'd0);
    last = cyc;
    wait_ret(1'b0, lat, ok);
    if (ok) begin
      chk("restart_ld_pc",  32'(pc),  32'h0002);
      chk("restart_ld_lat", 32'(lat), 32'd5);
      chk("restart_ld_r4",  32'(u_dut.rf[4]), 32'h0002);
    end
    rst = 1'b1;

    // 32-bit data, 12-bit address core with PC wrap
    chk("w_rst_pc",  32'(pc32),  32'h0FFC);
    chk("w_rst_req", 32'(req32), 32'd0);
    rst32 = 1'b0;
    tick();
    chk("w_first_addr", 32'(addr32), 32'h0FFC);
    last = cyc;
    for (int i = 0; i < 4; i++) begin
      wait_ret(1'b1, lat, ok);
      if (ok) begin
        chk({tv32[i].name, "_pc"},  32'(pc32), tv32[i].pc);
        chk({tv32[i].name, "_lat"}, 32'(lat),  32'(tv32[i].lat));
        chk({tv32[i].name, "_reg"}, u_dut32.rf[tv32[i].rd], tv32[i].val);
      end
    end
    chk("w_fetch_wrap", 32'(saw_fetch0), 32'd1);
    chk("w_halted",     32'(halted32),   32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
